// File: rtl/shift_disp_rx_pkg.sv
// Shared constants and types for the serial display link receiver.
//   SEG_FRAME_BITS / LED_FRAME_BITS : frame lengths of the two display chains
//   rx_state_e                      : receiver FSM states
package shift_disp_rx_pkg;

  localparam int SEG_FRAME_BITS = 64;
  localparam int LED_FRAME_BITS = 16;

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,  // first cycle after reset, edge detectors loading
    ST_IDLE  = 2'd1,  // no bits shifted since last latch
    ST_SHIFT = 2'd2   // at least one bit shifted since last latch
  } rx_state_e;

  // bit_cnt width: must hold WIDTH+1
  function automatic int bit_cnt_w(input int width);
    return $clog2(width) + 2;
  endfunction

endpackage

// File: rtl/shift_disp_rx_if.sv
// Serial display link plus the receiver's parallel view of it.
//   master : drives ser_clk/ser_do/ser_en, observes the parallel side
//   slave  : the receiver; samples the serial lines, drives par_* and counters
interface shift_disp_rx_if
  import shift_disp_rx_pkg::*;
#(
  parameter int WIDTH = SEG_FRAME_BITS,
  parameter int CNT_W = 16
) ();
  localparam int BW = bit_cnt_w(WIDTH);

  logic             ser_clk;
  logic             ser_do;
  logic             ser_en;
  logic [WIDTH-1:0] par_data;
  logic             par_valid;
  logic             frame_err;
  logic [BW-1:0]    bit_cnt;
  logic [CNT_W-1:0] frame_cnt;

  modport master (
    output ser_clk, ser_do, ser_en,
    input  par_data, par_valid, frame_err, bit_cnt, frame_cnt
  );

  modport slave (
    input  ser_clk, ser_do, ser_en,
    output par_data, par_valid, frame_err, bit_cnt, frame_cnt
  );
endinterface

// File: rtl/shift_disp_rx_sync_edge.sv
// Synchronizer + rising-edge detector for one asynchronous serial line.
//   clk, rstn : system clock, synchronous active-low reset
//   prime     : receiver FSM in PRIME; suppresses edge reporting
//   d         : asynchronous input line
//   level     : synchronized level (SYNC_STAGES flops after d)
//   rise      : one-cycle pulse on a synchronized 0->1 transition
module shift_disp_rx_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic prime,
  input  logic d,
  output logic level,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  // Fills with ones after reset; the top bit says both level and prev hold
  // real post-reset samples, so a line already high at reset release is
  // seen as a steady level rather than an edge.
  logic [SYNC_STAGES:0]   vld_pipe;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync     <= '0;
      prev     <= 1'b0;
      vld_pipe <= '0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], d};
      prev     <= sync[SYNC_STAGES-1];
      vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign level = sync[SYNC_STAGES-1];
  assign rise  = level & ~prev & vld_pipe[SYNC_STAGES] & ~prime;
endmodule

// File: rtl/shift_disp_rx.sv
// Receiving end of the serial display link: models the board's shift-register
// chain in the clk domain. Shifts one bit per ser_clk rise (MSB first) and
// transfers the frame to par_data on each ser_en rise.
//   clk, rstn : system clock (>= 4x ser_clk), synchronous active-low reset
//   bus       : slave side of shift_disp_rx_if (ser_* in; par_data, par_valid,
//               frame_err, bit_cnt, frame_cnt out)
module shift_disp_rx
  import shift_disp_rx_pkg::*;
#(
  parameter int WIDTH       = SEG_FRAME_BITS,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  shift_disp_rx_if.slave       bus
);
  localparam int            BW   = bit_cnt_w(WIDTH);
  localparam logic [BW-1:0] FULL = BW'(WIDTH);
  localparam logic [BW-1:0] SAT  = BW'(WIDTH + 1);

  rx_state_e        state, state_nxt;
  logic             prime;
  logic             clk_lvl, clk_rise, en_lvl, en_rise, do_lvl, do_rise;
  logic             clk_evt, en_evt, do_bit;
  logic             do_shift, do_latch;
  logic [WIDTH-1:0] sreg, sreg_nxt, par_data;
  logic [BW-1:0]    bit_cnt, cnt_nxt;
  logic [CNT_W-1:0] frame_cnt;
  logic             par_valid, frame_err;

  assign prime = (state == ST_PRIME);

  // Equal-depth synchronizers keep ser_do aligned with ser_clk.
  shift_disp_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rstn(rstn), .prime(prime), .d(bus.ser_clk), .level(clk_lvl), .rise(clk_rise));
  shift_disp_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_en (
    .clk(clk), .rstn(rstn), .prime(prime), .d(bus.ser_en), .level(en_lvl), .rise(en_rise));
  shift_disp_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_do (
    .clk(clk), .rstn(rstn), .prime(prime), .d(bus.ser_do), .level(do_lvl), .rise(do_rise));

  // A rise pulse implies the level is high, so these reduce to the rise
  // pulses and the data level respectively.
  assign clk_evt = clk_rise & clk_lvl;
  assign en_evt  = en_rise & en_lvl;
  assign do_bit  = do_lvl | do_rise;

  always_comb begin
    state_nxt = state;
    do_shift  = 1'b0;
    do_latch  = 1'b0;
    case (state)
      ST_PRIME: state_nxt = ST_IDLE;
      ST_IDLE, ST_SHIFT: begin
        do_shift = clk_evt;
        do_latch = en_evt;
        if (en_evt)       state_nxt = ST_IDLE;
        else if (clk_evt) state_nxt = ST_SHIFT;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Shift happens before latch in the same cycle, so the latch sees it.
  always_comb begin
    sreg_nxt = sreg;
    cnt_nxt  = bit_cnt;
    if (do_shift) begin
      sreg_nxt = {sreg[WIDTH-2:0], do_bit};
      cnt_nxt  = (bit_cnt >= SAT) ? SAT : bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_PRIME;
      sreg      <= '0;
      par_data  <= '0;
      par_valid <= 1'b0;
      frame_err <= 1'b0;
      bit_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      sreg      <= sreg_nxt;          // never cleared on latch, like the chain
      par_valid <= do_latch;
      bit_cnt   <= do_latch ? '0 : cnt_nxt;
      if (do_latch) begin
        par_data  <= sreg_nxt;
        frame_err <= (cnt_nxt != FULL);
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign bus.par_data  = par_data;
  assign bus.par_valid = par_valid;
  assign bus.frame_err = frame_err;
  assign bus.bit_cnt   = bit_cnt;
  assign bus.frame_cnt = frame_cnt;
endmodule

// File: tb/tb_shift_disp_rx.sv
module tb_shift_disp_rx;
  import shift_disp_rx_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  logic ser_clk, ser_do, ser_en;
  int   tests = 0;
  int   fails = 0;
  int   exp_fc = 0;

  always #5 clk = ~clk;

  shift_disp_rx_if #(.WIDTH(LED_FRAME_BITS), .CNT_W(8))  led_if ();
  shift_disp_rx_if #(.WIDTH(SEG_FRAME_BITS), .CNT_W(16)) seg_if ();

  assign led_if.ser_clk = ser_clk;
  assign led_if.ser_do  = ser_do;
  assign led_if.ser_en  = ser_en;
  assign seg_if.ser_clk = ser_clk;
  assign seg_if.ser_do  = ser_do;
  assign seg_if.ser_en  = ser_en;

  shift_disp_rx #(.WIDTH(LED_FRAME_BITS), .SYNC_STAGES(2), .CNT_W(8)) dut_led (
    .clk(clk), .rstn(rstn), .bus(led_if));
  shift_disp_rx #(.WIDTH(SEG_FRAME_BITS), .SYNC_STAGES(2), .CNT_W(16)) dut_seg (
    .clk(clk), .rstn(rstn), .bus(seg_if));

  task automatic send_bit(input logic b);
    ser_do = b;
    repeat (4) @(negedge clk);
    ser_clk = 1'b1;
    repeat (4) @(negedge clk);
    ser_clk = 1'b0;
  endtask

  task automatic send16(input logic [15:0] v, input int n);
    for (int i = 15; i > 15 - n; i--) send_bit(v[i]);
  endtask

  // Pulse ser_en; report par_valid pulse count and the values seen with them.
  task automatic pulse_en(output int np, output logic [15:0] pd, output logic fe,
                          output logic [63:0] wpd, output logic wfe);
    np = 0; pd = '0; fe = 1'b0; wpd = '0; wfe = 1'b0;
    ser_en = 1'b1;
    repeat (6) @(negedge clk) begin
      if (led_if.par_valid) begin np++; pd = led_if.par_data; fe = led_if.frame_err; end
      if (seg_if.par_valid) begin wpd = seg_if.par_data; wfe = seg_if.frame_err; end
    end
    ser_en = 1'b0;
    repeat (4) @(negedge clk) if (led_if.par_valid) np++;
  endtask

  task automatic test_reset();
    int np = 0;
    ser_clk = 1'b1; ser_en = 1'b1; ser_do = 1'b1; rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk) if (led_if.par_valid) np++;
    tests++; if (np !== 0) begin fails++; $display("FAIL reset_valid got %0d pulses want 0", np); end
    tests++; if (led_if.bit_cnt !== 6'd0) begin fails++; $display("FAIL reset_bitcnt got %0d want 0", led_if.bit_cnt); end
    tests++; if (led_if.par_data !== 16'h0 || led_if.frame_err !== 1'b0) begin fails++;
      $display("FAIL reset_data got %h/%b want 0000/0", led_if.par_data, led_if.frame_err); end
    tests++; if (led_if.frame_cnt !== 8'd0) begin fails++; $display("FAIL reset_fcnt got %0d want 0", led_if.frame_cnt); end
    // falling edges must not shift or latch
    ser_clk = 1'b0; ser_en = 1'b0; ser_do = 1'b0;
    np = 0;
    repeat (8) @(negedge clk) if (led_if.par_valid) np++;
    tests++; if (np !== 0 || led_if.bit_cnt !== 6'd0) begin fails++;
      $display("FAIL fall_edge got pulses=%0d bit_cnt=%0d want 0/0", np, led_if.bit_cnt); end
  endtask

  task automatic test_basic();
    int np; logic [15:0] pd; logic fe; logic [63:0] wpd; logic wfe;
    send16(16'hA5C3, 16);
    tests++; if (led_if.bit_cnt !== 6'd16) begin fails++; $display("FAIL basic_bitcnt got %0d want 16", led_if.bit_cnt); end
    pulse_en(np, pd, fe, wpd, wfe); exp_fc++;
    tests++; if (np !== 1) begin fails++; $display("FAIL basic_pulse got %0d want 1", np); end
    tests++; if (pd !== 16'hA5C3 || fe !== 1'b0) begin fails++;
      $display("FAIL basic_data got %h/%b want a5c3/0", pd, fe); end
    tests++; if (led_if.frame_cnt !== 8'd1) begin fails++; $display("FAIL basic_fcnt got %0d want 1", led_if.frame_cnt); end
  endtask

  task automatic test_short();
    int np; logic [15:0] pd; logic fe; logic [63:0] wpd; logic wfe;
    send16(16'h1234, 15);
    tests++; if (led_if.bit_cnt !== 6'd15) begin fails++; $display("FAIL short_bitcnt got %0d want 15", led_if.bit_cnt); end
    pulse_en(np, pd, fe, wpd, wfe); exp_fc++;
    // chain held a5c3; 15 new bits of 1234 push in 0x091a after the old LSB
    tests++; if (pd !== 16'h891A || fe !== 1'b1) begin fails++;
      $display("FAIL short_data got %h/%b want 891a/1", pd, fe); end
    tests++; if (led_if.bit_cnt !== 6'd0) begin fails++; $display("FAIL short_clr got %0d want 0", led_if.bit_cnt); end
  endtask

  task automatic test_overrun();
    int np; logic [15:0] pd; logic fe; logic [63:0] wpd; logic wfe;
    send_bit(1'b1); send_bit(1'b1);
    send16(16'hFFFF, 15);
    tests++; if (led_if.bit_cnt !== 6'd17) begin fails++; $display("FAIL ovr_bitcnt17 got %0d want 17", led_if.bit_cnt); end
    send_bit(1'b1);
    tests++; if (led_if.bit_cnt !== 6'd17) begin fails++; $display("FAIL ovr_sat got %0d want 17", led_if.bit_cnt); end
    pulse_en(np, pd, fe, wpd, wfe); exp_fc++;
    tests++; if (pd !== 16'hFFFF || fe !== 1'b1 || np !== 1) begin fails++;
      $display("FAIL ovr_data got %h/%b/%0d want ffff/1/1", pd, fe, np); end
  endtask

  task automatic test_simultaneous();
    int np = 0; logic [15:0] pd = '0; logic fe = 1'b1;
    send16(16'h5A3C, 15);
    ser_do = 1'b0;
    repeat (4) @(negedge clk);
    ser_clk = 1'b1; ser_en = 1'b1;
    repeat (8) @(negedge clk)
      if (led_if.par_valid) begin np++; pd = led_if.par_data; fe = led_if.frame_err; end
    ser_clk = 1'b0; ser_en = 1'b0;
    repeat (4) @(negedge clk);
    exp_fc++;
    tests++; if (np !== 1 || pd !== 16'h5A3C || fe !== 1'b0) begin fails++;
      $display("FAIL simul got %h/%b/%0d want 5a3c/0/1", pd, fe, np); end
    tests++; if (led_if.bit_cnt !== 6'd0) begin fails++; $display("FAIL simul_clr got %0d want 0", led_if.bit_cnt); end
  endtask

  task automatic test_wide();
    int np; logic [15:0] pd; logic fe; logic [63:0] wpd; logic wfe;
    logic [63:0] pat;
    pat = 64'hDEAD_BEEF_0123_4567;
    for (int i = 63; i >= 0; i--) send_bit(pat[i]);
    pulse_en(np, pd, fe, wpd, wfe); exp_fc++;
    tests++; if (wpd !== 64'hDEAD_BEEF_0123_4567 || wfe !== 1'b0) begin fails++;
      $display("FAIL wide_data got %h/%b want deadbeef01234567/0", wpd, wfe); end
    tests++; if (pd !== 16'h4567 || fe !== 1'b1) begin fails++;
      $display("FAIL wide_led got %h/%b want 4567/1", pd, fe); end
    tests++; if (seg_if.frame_cnt !== 16'(exp_fc)) begin fails++;
      $display("FAIL wide_fcnt got %0d want %0d", seg_if.frame_cnt, exp_fc); end
  endtask

  task automatic test_reset_midframe();
    int np; logic [15:0] pd; logic fe; logic [63:0] wpd; logic wfe;
    send16(16'hFF00, 8);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1; exp_fc = 0;
    repeat (6) @(negedge clk);
    tests++; if (led_if.bit_cnt !== 6'd0 || led_if.par_data !== 16'h0) begin fails++;
      $display("FAIL midrst_clr got %0d/%h want 0/0000", led_if.bit_cnt, led_if.par_data); end
    send16(16'h0001, 16);
    pulse_en(np, pd, fe, wpd, wfe); exp_fc++;
    tests++; if (pd !== 16'h0001 || fe !== 1'b0 || led_if.frame_cnt !== 8'd1) begin fails++;
      $display("FAIL midrst got %h/%b/%0d want 0001/0/1", pd, fe, led_if.frame_cnt); end
  endtask

  task automatic test_back_to_back();
    int np, tot = 0; logic [15:0] pd; logic fe; logic [63:0] wpd; logic wfe;
    for (int i = 0; i < 255; i++) begin
      pulse_en(np, pd, fe, wpd, wfe);
      tot += np;
      exp_fc = (exp_fc + 1) % 256;
    end
    tests++; if (tot !== 255) begin fails++; $display("FAIL b2b_pulses got %0d want 255", tot); end
    tests++; if (led_if.frame_cnt !== 8'(exp_fc) || exp_fc != 0) begin fails++;
      $display("FAIL b2b_wrap got %0d want 0", led_if.frame_cnt); end
    tests++; if (led_if.par_data !== 16'h0001 || led_if.frame_err !== 1'b1) begin fails++;
      $display("FAIL b2b_empty got %h/%b want 0001/1", led_if.par_data, led_if.frame_err); end
  endtask

  initial begin
    ser_clk = 1'b0; ser_en = 1'b0; ser_do = 1'b0; rstn = 1'b0;
    test_reset();
    test_basic();
    test_short();
    test_overrun();
    test_simultaneous();
    test_wide();
    test_reset_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
